// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the pixel read path.
package vga_pkg;
    localparam int LINEPIX_DEF = 640;
    localparam int BGCOLOR_DEF = 0;
    localparam int UCNT_W      = 16;
    function automatic int ppw(input int wwidth, input int pwidth);
        return wwidth / pwidth;
    endfunction
endpackage

// File: rtl/pixel_shifter.sv
// pixel_shifter: LSB-first word shift register with a remaining-pixel counter and load decision.
module pixel_shifter import vga_pkg::*; #(
    parameter int WWIDTH = 8,
    parameter int PWIDTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              consume_i,
    input  logic              src_valid_i,
    input  logic [WWIDTH-1:0] src_i,
    output logic              load_o,
    output logic              avail_o,
    output logic [PWIDTH-1:0] pixel_o
);
    localparam int PPW = ppw(WWIDTH, PWIDTH);
    localparam int RW  = $clog2(PPW + 1);
    logic [WWIDTH-1:0] shift_q, shift_d;
    logic [RW-1:0]     rem_q, rem_d, rem_eff;
    // A line start discards the partial word, so the load rule sees an empty register.
    always_comb begin
        rem_eff = clear_i ? '0 : rem_q;
        load_o  = src_valid_i & ((rem_eff == '0) | ((rem_eff == RW'(1)) & consume_i));
        shift_d = load_o ? src_i : consume_i ? shift_q >> PWIDTH : shift_q;
        rem_d   = load_o ? RW'(PPW) : consume_i ? rem_eff - RW'(1) : rem_eff;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            shift_q <= shift_d;
            rem_q   <= rem_d;
        end
    end
    assign avail_o = rem_q != '0;
    assign pixel_o = shift_q[PWIDTH-1:0];
endmodule

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: FIFO word prefetch and per-cycle pixel emission with underrun/overscan handling.
// Optional PIXEL_UNPACKER_UNDERRUN_COUNT_EN adds a saturating underrun_count_o port.
module pixel_unpacker import vga_pkg::*; #(
    parameter int WWIDTH  = 8,
    parameter int PWIDTH  = 2,
    parameter int LINEPIX = LINEPIX_DEF,
    parameter int BGCOLOR = BGCOLOR_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WWIDTH-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_read_o,
    input  logic              pixel_en_i,
    input  logic              line_start_i,
    output logic [PWIDTH-1:0] pixel_out_o,
    output logic              pixel_valid_o,
    output logic              underrun_o
`ifdef PIXEL_UNPACKER_UNDERRUN_COUNT_EN
    ,
    output logic [UCNT_W-1:0] underrun_count_o
`endif
);
    localparam int LW = $clog2(LINEPIX + 1);
    localparam logic [PWIDTH-1:0] BG = BGCOLOR[PWIDTH-1:0];
    logic [WWIDTH-1:0] pref_q, pref_d;
    logic              pref_valid_q, pref_valid_d, pending_q;
    logic [LW-1:0]     line_q, line_d;
    logic              en, overscan, consume, under, avail, load;
    logic [PWIDTH-1:0] pix;
    pixel_shifter #(.WWIDTH(WWIDTH), .PWIDTH(PWIDTH)) u_shifter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (line_start_i),
        .consume_i  (consume),
        .src_valid_i(pref_valid_q | pending_q),
        .src_i      (pref_valid_q ? pref_q : fifo_data_i),
        .load_o     (load),
        .avail_o    (avail),
        .pixel_o    (pix)
    );
    // A pending read delivering into a load bypasses prefetch entirely.
    always_comb begin
        en           = pixel_en_i & ~line_start_i;
        overscan     = line_q == LW'(LINEPIX);
        consume      = en & avail & ~overscan;
        under        = en & ~avail & ~overscan;
        fifo_read_o  = ~pref_valid_q & ~pending_q & ~fifo_empty_i & ~reset_i;
        pref_valid_d = (pref_valid_q | pending_q) & ~load;
        pref_d       = pending_q ? fifo_data_i : pref_q;
        line_d       = line_start_i ? '0 : line_q + LW'(consume);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pref_q        <= '0;
            pref_valid_q  <= 1'b0;
            pending_q     <= 1'b0;
            line_q        <= '0;
            pixel_out_o   <= BG;
            pixel_valid_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            pref_q        <= pref_d;
            pref_valid_q  <= pref_valid_d;
            pending_q     <= fifo_read_o;
            line_q        <= line_d;
            pixel_out_o   <= consume ? pix : BG;
            pixel_valid_o <= consume;
            underrun_o    <= underrun_o | under;
        end
    end
`ifdef PIXEL_UNPACKER_UNDERRUN_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) underrun_count_o <= '0;
        else if (under && underrun_count_o != '1) underrun_count_o <= underrun_count_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: directed self-checking bench with a behavioural 1-cycle-latency FIFO.
module tb_pixel_unpacker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_data = '0;
    logic       fifo_empty;
    logic       fifo_read;
    logic       pixel_en = 1'b0;
    logic       line_start = 1'b0;
    logic [1:0] pixel_out;
    logic       pixel_valid;
    logic       underrun;
`ifdef PIXEL_UNPACKER_UNDERRUN_COUNT_EN
    logic [15:0] ucnt;
`endif
    logic [7:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int checks = 0;
    int errors = 0;
    int p0;

    always #5 clk = ~clk;

    pixel_unpacker #(.LINEPIX(8)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .fifo_data_i  (fifo_data),
        .fifo_empty_i (fifo_empty),
        .fifo_read_o  (fifo_read),
        .pixel_en_i   (pixel_en),
        .line_start_i (line_start),
        .pixel_out_o  (pixel_out),
        .pixel_valid_o(pixel_valid),
        .underrun_o   (underrun)
`ifdef PIXEL_UNPACKER_UNDERRUN_COUNT_EN
        ,
        .underrun_count_o(ucnt)
`endif
    );

    assign fifo_empty = rd_ptr == wr_ptr;
    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    typedef struct {
        logic       en;
        logic       ls;
        logic [1:0] pix;
        logic       vld;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic ls);
        pixel_en   = en;
        line_start = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_ptr = rd_ptr;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        p0 = rd_ptr;
    endtask

    task automatic pix_chk(input string name, input logic [1:0] p, input logic v);
        chk({name, "_pix"}, 32'(pixel_out), 32'(p));
        chk({name, "_vld"}, 32'(pixel_valid), 32'(v));
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'd0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 2'd1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 2'd2, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 2'd3, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 2'd3, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 2'd2, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 2'd1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 2'd0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 2'd0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 2'd0, 1'b0};

        // Two words, eight pixels, exactly two pops
        do_reset();
        pix_chk("reset", 2'd0, 1'b0);
        chk("reset_underrun", 32'(underrun), 0);
        chk("reset_read", 32'(fifo_read), 0);
`ifdef PIXEL_UNPACKER_UNDERRUN_COUNT_EN
        chk("reset_ucnt", 32'(ucnt), 0);
`endif
        push(8'hE4);
        push(8'h1B);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].en, tbl[i].ls);
            pix_chk($sformatf("stream%0d", i), tbl[i].pix, tbl[i].vld);
        end
        chk("stream_pops", 32'(rd_ptr - p0), 2);
        chk("stream_underrun", 32'(underrun), 0);

        // Empty FIFO underrun
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            pix_chk($sformatf("empty%0d", i), 2'd0, 1'b0);
        end
        chk("empty_underrun", 32'(underrun), 1);
        chk("empty_pops", 32'(rd_ptr - p0), 0);
`ifdef PIXEL_UNPACKER_UNDERRUN_COUNT_EN
        chk("empty_ucnt", 32'(ucnt), 3);
`endif

        // Stalled PixelEn keeps the next word in prefetch
        do_reset();
        push(8'hE4);
        push(8'h1B);
        push(8'h4E);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); pix_chk("stall0", 2'd0, 1'b1);
        cyc(1'b0, 1'b0); pix_chk("stall1", 2'd0, 1'b0);
        cyc(1'b1, 1'b0); pix_chk("stall2", 2'd1, 1'b1);
        cyc(1'b0, 1'b0); pix_chk("stall3", 2'd0, 1'b0);
        cyc(1'b1, 1'b0); pix_chk("stall4", 2'd2, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("stall_pops", 32'(rd_ptr - p0), 2);
        chk("stall_underrun", 32'(underrun), 0);

        // LineStart discards the partial word; PixelEn in that cycle is ignored
        do_reset();
        push(8'hE4);
        push(8'h1B);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); pix_chk("ls0", 2'd0, 1'b1);
        cyc(1'b1, 1'b0); pix_chk("ls1", 2'd1, 1'b1);
        cyc(1'b1, 1'b1); pix_chk("ls_pulse", 2'd0, 1'b0);
        cyc(1'b1, 1'b0); pix_chk("ls2", 2'd3, 1'b1);
        cyc(1'b1, 1'b0); pix_chk("ls3", 2'd2, 1'b1);
        chk("ls_underrun", 32'(underrun), 0);

        // Overscan guard at LINEPIX = 8
        do_reset();
        push(8'hE4);
        push(8'h1B);
        push(8'h4E);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].en, tbl[i].ls);
            pix_chk($sformatf("ovs%0d", i), tbl[i].pix, tbl[i].vld);
        end
        chk("ovs_underrun", 32'(underrun), 0);
        chk("ovs_pops", 32'(rd_ptr - p0), 3);

        // Reset while a read is in flight drops the returned word
        do_reset();
        push(8'hE4);
        push(8'h1B);
        #1;
        chk("inflight_read", 32'(fifo_read), 1);
        cyc(1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        pix_chk("inflight_rst", 2'd0, 1'b0);
        chk("inflight_underrun", 32'(underrun), 0);
        chk("inflight_read_blocked", 32'(fifo_read), 0);
        cyc(1'b1, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        pix_chk("inflight_next", 2'd3, 1'b1);
        chk("inflight_pops", 32'(rd_ptr - p0), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
